// File: rtl/cmd_pkg.sv
// ----------------------------------------------------------------------------
// cmd_pkg
// Shared types and constants for the command dispatcher and its register file.
//   opcode_t  : command opcodes carried in cmd[23:20]
//   state_t   : dispatcher FSM states
//   cmd_t     : field view of the 24-bit command word
//   CNT_ADDR  : reserved address that reads back the command counter
//   DEFAULT_* : default response bytes
// ----------------------------------------------------------------------------
package cmd_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_WRITE = 4'h1,
        OP_READ  = 4'h2
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        SEND,
        WAIT
    } state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  addr;
        logic [15:0] data;
    } cmd_t;

    localparam logic [3:0] CNT_ADDR     = 4'hF;
    localparam logic [7:0] DEFAULT_ACK  = 8'hA5;
    localparam logic [7:0] DEFAULT_NACK = 8'hEE;

endpackage

// File: rtl/cmd_regfile.sv
// ----------------------------------------------------------------------------
// cmd_regfile
// NUM_REGS x 16-bit register file with one synchronous write port and one
// combinational read port. Every register is also exported on a flat bus.
//   clk      in   system clock
//   rst      in   synchronous active-high reset, clears every register
//   we       in   write enable
//   waddr    in   write address (ignored when >= NUM_REGS)
//   wdata    in   write data
//   raddr    in   read address (reads 0 when >= NUM_REGS)
//   rdata    out  read data
//   regs_out out  flattened registers, reg i at [16*i+15:16*i]
// ----------------------------------------------------------------------------
module cmd_regfile #(
    parameter int NUM_REGS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [3:0]              waddr,
    input  logic [15:0]             wdata,
    input  logic [3:0]              raddr,
    output logic [15:0]             rdata,
    output logic [NUM_REGS*16-1:0]  regs_out
);

    logic [15:0] mem [NUM_REGS];

    // NOTE: this storage is reset on purpose; it is a handful of flops that
    // drive live control outputs, not a RAM macro, so it must never come out
    // of reset holding garbage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (waddr == 4'(i)) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

    // Address compare per entry keeps out-of-range addresses harmless for any
    // NUM_REGS, including non-powers of two.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr == 4'(i)) begin
                rdata = mem[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_out[16*g +: 16] = mem[g];
    end

endmodule

// File: rtl/cmd_dispatch.sv
// ----------------------------------------------------------------------------
// cmd_dispatch
// Executes 24-bit commands from the UART command wrapper against a small
// register file and answers with an ACK/NACK byte or two read-data bytes.
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   cmd_rdy      in   complete command available from the wrapper
//   cmd          in   [23:20] opcode, [19:16] addr, [15:0] data
//   clr_cmd_rdy  out  one-cycle pulse consuming the current command
//   trmt         out  one-cycle pulse starting a UART byte transmit
//   tx_data      out  byte to transmit, held from trmt until tx_done
//   tx_done      in   UART transmit complete (level)
//   regs_out     out  flattened register file, reg i at [16*i+15:16*i]
//   busy         out  high whenever the FSM is not in IDLE
//   cmd_cnt      out  number of commands consumed, wraps silently
// ----------------------------------------------------------------------------
module cmd_dispatch
    import cmd_pkg::*;
#(
    parameter int         NUM_REGS  = 8,
    parameter logic [7:0] ACK_BYTE  = DEFAULT_ACK,
    parameter logic [7:0] NACK_BYTE = DEFAULT_NACK
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_rdy,
    input  logic [23:0]             cmd,
    output logic                    clr_cmd_rdy,
    output logic                    trmt,
    output logic [7:0]              tx_data,
    input  logic                    tx_done,
    output logic [NUM_REGS*16-1:0]  regs_out,
    output logic                    busy,
    output logic [15:0]             cmd_cnt
);

    state_t      state;
    cmd_t        cmd_q;
    logic        second_pending;   // a READ still owes its low byte
    logic [7:0]  low_byte;         // low byte captured at EXEC time

    logic        in_range;
    logic        write_ok;
    logic        is_read;
    logic        reg_we;
    logic [15:0] reg_rdata;
    logic [15:0] rd_word;
    logic [7:0]  resp_byte;

    cmd_regfile #(
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (reg_we),
        .waddr    (cmd_q.addr),
        .wdata    (cmd_q.data),
        .raddr    (cmd_q.addr),
        .rdata    (reg_rdata),
        .regs_out (regs_out)
    );

    // Decode of the latched command; only consumed while in EXEC.
    // NOTE: every output of this block gets a default before the case, so no
    // path through it can leave a value unassigned and infer a latch.
    always_comb begin
        in_range  = (cmd_q.addr < 4'(NUM_REGS));
        write_ok  = 1'b0;
        is_read   = 1'b0;
        rd_word   = '0;
        resp_byte = NACK_BYTE;
        case (cmd_q.op)
            OP_NOP: begin
                resp_byte = ACK_BYTE;
            end
            OP_WRITE: begin
                if (in_range) begin
                    write_ok  = 1'b1;
                    resp_byte = ACK_BYTE;
                end
            end
            OP_READ: begin
                if (in_range) begin
                    is_read = 1'b1;
                    rd_word = reg_rdata;
                end else if (cmd_q.addr == CNT_ADDR) begin
                    is_read = 1'b1;
                    rd_word = cmd_cnt;
                end
            end
            default: ;
        endcase
        if (is_read) begin
            resp_byte = rd_word[15:8];
        end
    end

    assign reg_we      = (state == EXEC) && write_ok;
    assign clr_cmd_rdy = (state == IDLE) && cmd_rdy;
    assign trmt        = (state == SEND);
    assign busy        = (state != IDLE);

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values; blocking assignments would make the result
    // depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cmd_q          <= '0;
            cmd_cnt        <= '0;
            tx_data        <= '0;
            second_pending <= 1'b0;
            low_byte       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_rdy) begin
                        cmd_q   <= cmd_t'(cmd);
                        cmd_cnt <= cmd_cnt + 16'd1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    // Both read bytes are captured now so later writes or
                    // counter changes cannot alter the low byte.
                    tx_data        <= resp_byte;
                    low_byte       <= rd_word[7:0];
                    second_pending <= is_read;
                    state          <= SEND;
                end
                SEND: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // WAIT begins a cycle after trmt, by which time the UART
                    // has dropped tx_done from the previous byte.
                    if (tx_done) begin
                        if (second_pending) begin
                            tx_data        <= low_byte;
                            second_pending <= 1'b0;
                            state          <= SEND;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cmd_dispatch.md
Name: cmd_dispatch

Overview:
Consumes the 24-bit commands assembled by the UART command wrapper (cmd/cmd_rdy/clr_cmd_rdy) and executes them against a small 16-bit register file. Returns one ack/nack byte or two read-data bytes through the wrapper's transmit port (trmt/tx_data/tx_done). Sits directly downstream of the UART command wrapper. Its register file drives the rest of the design.

Parameters:
NUM_REGS, 8, number of 16-bit read/write registers (1..15); address 4'hF is reserved.
ACK_BYTE, 8'hA5, response byte for successful write or nop.
NACK_BYTE, 8'hEE, response byte for illegal opcode or address.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
cmd_rdy  in  1  complete command available from wrapper
cmd  in  24  command: [23:20] opcode, [19:16] addr, [15:0] data
clr_cmd_rdy  out  1  one-cycle pulse; consumes current command
trmt  out  1  one-cycle pulse; starts a UART byte transmit
tx_data  out  8  byte to transmit; registered, stable from trmt until tx_done
tx_done  in  1  UART transmit complete (level; cleared by UART on trmt)
regs_out  out  NUM_REGS*16  flattened register file; reg i at [16*i+15:16*i]
busy  out  1  high in every state except IDLE
cmd_cnt  out  16  count of commands consumed, wraps at 16'hFFFF->0

Behaviour:
- Reset (sampled on clk edge while rst=1): state=IDLE; all regs_out=0; cmd_cnt=0; tx_data=0; trmt=0; clr_cmd_rdy=0; busy=0. Reset mid-transmit drops trmt immediately. No second byte is sent.
- Opcodes: 4'h0 NOP -> ACK. 4'h1 WRITE reg[addr]<=data -> ACK. 4'h2 READ -> data[15:8], then data[7:0]. All other opcodes -> NACK, no state change.
- Addressing: addr<NUM_REGS is legal for WRITE/READ. addr==4'hF on READ returns cmd_cnt. addr==4'hF on WRITE -> NACK. Any other addr>=NUM_REGS -> NACK, no write. NOP ignores addr.
- State machine (registered state, combinational outputs except tx_data):
  - IDLE: if cmd_rdy, latch cmd into cmd_q, assert clr_cmd_rdy this cycle, increment cmd_cnt, go EXEC. Otherwise stay.
  - EXEC: decode cmd_q. Perform the write; the new value is visible on regs_out next cycle. Load tx_data with ACK, NACK or the read high byte. Set the second-byte flag for a legal READ. Go SEND.
  - SEND: trmt=1 for exactly one cycle; go WAIT.
  - WAIT: hold until tx_done=1. Then, if the second-byte flag is set, load tx_data with the low byte, clear the flag and go SEND. Otherwise go IDLE.
- Latency: cmd_rdy at cycle 0 -> clr_cmd_rdy cycle 0 -> write visible cycle 2 -> trmt cycle 2.
- READ data is captured in EXEC, so the low byte is unaffected by later events. Every command's count increments before its own EXEC, so READ 0xF reports the count including itself.
- cmd_rdy while busy: ignored. The wrapper holds the command until clr_cmd_rdy.
- Back-to-back: a command pending on return to IDLE is accepted that same IDLE cycle.
- tx_done is sampled only in WAIT. WAIT starts one cycle after trmt, so a stale tx_done from the previous byte is already cleared.
- cmd_cnt wraps silently.

Decomposition:
- Package cmd_pkg: opcode enum (OP_NOP, OP_WRITE, OP_READ), dispatcher state enum (IDLE, EXEC, SEND, WAIT), CNT_ADDR=4'hF, default ACK/NACK constants.
- Sub-module cmd_regfile: NUM_REGS x 16 storage with synchronous reset and single write port (we, waddr, wdata). It drives regs_out. The FSM, response logic and counter stay in cmd_dispatch.

Test Plan:
- Reset mid-READ after the first byte's trmt -> trmt never re-asserts; busy=0, cmd_cnt=0, regs_out=0 next cycle.
- cmd=24'h11_1234 -> clr_cmd_rdy same cycle; reg1=16'h1234 two cycles later; one trmt with tx_data=8'hA5; after tx_done, busy=0, cmd_cnt=1.
- WRITE 24'h12_BEEF then READ cmd=24'h22_0000 -> two trmt pulses with tx_data 8'hBE then 8'hEF. The second trmt occurs only after the first tx_done.
- Illegal opcode cmd=24'h73_5555 and WRITE to addr 9 (NUM_REGS=8) cmd=24'h19_0001 -> each returns 8'hEE; regs_out unchanged.
- cmd_rdy held high across a whole transaction -> exactly one clr_cmd_rdy per command; the next command is accepted in the first IDLE cycle after tx_done.
- Three commands, then READ cmd=24'h2F_0000 -> tx bytes 8'h00, 8'h04. Separately, preload cmd_cnt=16'hFFFF by force and send one command -> cmd_cnt wraps to 0.
